spi_target: RTL and testbench

//  SPI target (slave) endpoint; counterpart of the SPI host controller. Samples external
//  SCK/CS_N/MOSI through synchronizers into the clk domain and drives MISO. Received words
//  go out on a one-cycle valid strobe; transmit words come in through a one-entry

---
 rtl/spi_target.sv | 200 ++++++++++++++++++++
 tb/tb_spi_target.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI target endpoint: synchronizes SCK/CS_N/MOSI into clk, shifts frames in and out in
// any CPOL/CPHA mode, with a one-entry transmit buffer and a one-cycle receive strobe.
module spi_target #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_cpol_i,
  input  logic              cfg_cpha_i,
  input  logic              cfg_lsb_first_i,
  input  logic              sck_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              tx_underrun_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int TXC_W = $clog2(DATA_W + 1);
  localparam int RXC_W = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;

  logic                   cpol_q, cpha_q, lsb_q;
  logic [DATA_W-1:0]      rx_sr, rx_next, rx_data_q;
  logic [RXC_W-1:0]       rx_cnt;
  logic [DATA_W-1:0]      tx_sr;
  logic [TXC_W-1:0]       tx_cnt;
  logic [DATA_W-1:0]      buf_q, load_word;
  logic                   buf_full;
  logic                   miso_q, rx_valid_q, underrun_q, frame_err_q;

  logic cs_fall, cs_rise, sck_edge, lead_edge, trail_edge;
  logic activate, deactivate, sample_en, shift_en, tx_reload, tx_take;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // CS syncs reset to deselected so a CS held low through reset still yields a select edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every flop samples the pre-edge values.
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall    = cs_d & ~cs_s;
  assign cs_rise    = ~cs_d & cs_s;
  assign sck_edge   = sck_s ^ sck_d;
  assign lead_edge  = sck_edge & (sck_d == cpol_q);
  assign trail_edge = sck_edge & (sck_s == cpol_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latches are inferred.
    state_d    = state_q;
    activate   = 1'b0;
    deactivate = 1'b0;
    case (state_q)
      IDLE:    if (cs_fall) begin state_d = ACTIVE; activate = 1'b1; end
      ACTIVE:  if (cs_rise) begin state_d = IDLE; deactivate = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  // Deselect wins over any SCK edge seen in the same cycle.
  assign sample_en = (state_q == ACTIVE) & ~cs_rise & (cpha_q ? trail_edge : lead_edge);
  assign shift_en  = (state_q == ACTIVE) & ~cs_rise & (cpha_q ? lead_edge : trail_edge);
  assign tx_reload = shift_en & (tx_cnt == TXC_W'(DATA_W));
  assign tx_take   = activate | tx_reload;
  assign load_word = buf_full ? buf_q : '0;
  assign rx_next   = lsb_q ? {mosi_s, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], mosi_s};

  // A word offered while empty is kept even if a reload drains the (empty) buffer that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
    end else begin
      if (tx_take) buf_full <= 1'b0;
      if (tx_valid_i && !buf_full) begin
        buf_q    <= tx_data_i;
        buf_full <= 1'b1;
      end
    end
  end

  // tx_cnt counts bits already presented; reaching DATA_W means the next shift edge reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      rx_sr       <= '0;
      rx_cnt      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_sr       <= '0;
      tx_cnt      <= '0;
      miso_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (activate) begin
        cpol_q     <= cfg_cpol_i;
        cpha_q     <= cfg_cpha_i;
        lsb_q      <= cfg_lsb_first_i;
        rx_cnt     <= '0;
        underrun_q <= ~buf_full;
        if (cfg_cpha_i) begin
          tx_sr  <= load_word;
          tx_cnt <= '0;
          miso_q <= 1'b0;
        end else begin
          miso_q <= first_bit(load_word, cfg_lsb_first_i);
          tx_sr  <= drop_bit(load_word, cfg_lsb_first_i);
          tx_cnt <= TXC_W'(1);
        end
      end else if (deactivate) begin
        miso_q      <= 1'b0;
        rx_cnt      <= '0;
        tx_cnt      <= '0;
        frame_err_q <= (rx_cnt != '0);
      end else begin
        if (sample_en) begin
          rx_sr <= rx_next;
          if (rx_cnt == RXC_W'(DATA_W - 1)) begin
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
            rx_cnt     <= '0;
          end else begin
            rx_cnt <= rx_cnt + RXC_W'(1);
          end
        end
        if (shift_en) begin
          if (tx_reload) begin
            underrun_q <= ~buf_full;
            miso_q     <= first_bit(load_word, lsb_q);
            tx_sr      <= drop_bit(load_word, lsb_q);
            tx_cnt     <= TXC_W'(1);
          end else begin
            miso_q <= first_bit(tx_sr, lsb_q);
            tx_sr  <= drop_bit(tx_sr, lsb_q);
            tx_cnt <= tx_cnt + TXC_W'(1);
          end
        end
      end
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = (state_q == ACTIVE);
  assign busy_o        = (state_q == ACTIVE);
  assign tx_ready_o    = ~buf_full;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;
  assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a bit-level SPI host drives table and random transactions; expected
// words and strobe counts come from the table or from a word-level model of the target.
`timescale 1ns/1ps
module tb_spi_target;

  localparam int HALF = 8;  // clk cycles per SCK half period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
  logic       sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_cpol_i(cfg_cpol), .cfg_cpha_i(cfg_cpha), .cfg_lsb_first_i(cfg_lsb),
    .sck_i(sck), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_underrun_o(tx_underrun), .frame_err_o(frame_err), .busy_o(busy)
  );

  typedef struct {
    logic        cpol, cpha, lsb;
    int          nfr;
    logic [15:0] mo;      // frame 0 in [7:0], frame 1 in [15:8]
    bit          pre;
    logic [7:0]  tx0;
    bit          mid;
    logic [7:0]  tx1;
    logic [15:0] exp_rx;
    logic [15:0] exp_mi;
    int          exp_und;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] rx_log[$];
  int         und_total  = 0;
  int         ferr_total = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid)    rx_log.push_back(rx_data);
      if (tx_underrun) und_total++;
      if (frame_err)   ferr_total++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic bit_of(input logic [15:0] w, input int i, input logic lsb);
    logic [7:0] f;
    f = w[(i / 8) * 8 +: 8];
    return lsb ? f[i % 8] : f[7 - (i % 8)];
  endfunction

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    else begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  // Host side: clocks nbits of mo out and reassembles what it captures on MISO into mi.
  task automatic xfer(input logic cpol, input logic cpha, input logic lsb, input int nbits,
                      input logic [15:0] mo, output logic [15:0] mi, input bit raise_cs);
    int idx;
    mi = '0;
    @(negedge clk);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb = lsb; sck = cpol;
    clk_wait(HALF);
    mosi = cpha ? 1'b0 : bit_of(mo, 0, lsb);
    cs_n = 1'b0;
    clk_wait(HALF);
    check("busy_selected", {31'd0, busy}, 32'd1);
    check("oe_selected", {31'd0, miso_oe}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      idx = (i / 8) * 8 + (lsb ? (i % 8) : 7 - (i % 8));
      if (cpha) begin
        sck = ~cpol; mosi = bit_of(mo, i, lsb);
        clk_wait(HALF);
        sck = cpol; mi[idx] = miso;
        clk_wait(HALF);
      end else begin
        sck = ~cpol; mi[idx] = miso;
        clk_wait(HALF);
        sck = cpol;
        if (i + 1 < nbits) mosi = bit_of(mo, i + 1, lsb);
        clk_wait(HALF);
      end
    end
    if (raise_cs) begin
      cs_n = 1'b1;
      clk_wait(HALF);
      check("busy_released", {31'd0, busy}, 32'd0);
      check("oe_released", {31'd0, miso_oe}, 32'd0);
      check("miso_released", {31'd0, miso}, 32'd0);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int          r0, u0, f0;
    logic [15:0] mi;
    r0 = rx_log.size(); u0 = und_total; f0 = ferr_total;
    if (v.pre) push_tx(v.tx0);
    if (v.mid) begin
      fork
        xfer(v.cpol, v.cpha, v.lsb, v.nfr * 8, v.mo, mi, 1'b1);
        begin clk_wait(40); push_tx(v.tx1); end
      join
    end else begin
      xfer(v.cpol, v.cpha, v.lsb, v.nfr * 8, v.mo, mi, 1'b1);
    end
    check({tag, "_rx_count"}, rx_log.size() - r0, v.nfr);
    for (int f = 0; f < v.nfr; f++) begin
      if (rx_log.size() > r0 + f) check({tag, "_rx_word"}, {24'd0, rx_log[r0 + f]}, {24'd0, v.exp_rx[f*8 +: 8]});
      check({tag, "_host_read"}, {24'd0, mi[f*8 +: 8]}, {24'd0, v.exp_mi[f*8 +: 8]});
    end
    check({tag, "_underruns"}, und_total - u0, v.exp_und);
    check({tag, "_frame_errs"}, ferr_total - f0, 0);
    check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
  endtask

  vec_t        vecs[5];
  vec_t        rv;
  logic [7:0]  last_rx;
  logic [15:0] mi;
  int          r0, f0;

  initial begin
    // mode 0 ends with a trailing edge that reloads the (empty) buffer, hence one underrun
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1, 16'h00A5, 1, 8'h3C, 0, 8'h00, 16'h00A5, 16'h003C, 1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1, 16'h0081, 1, 8'h0F, 0, 8'h00, 16'h0081, 16'h000F, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2, 16'h3412, 1, 8'hAA, 1, 8'h55, 16'h3412, 16'h55AA, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1, 16'h005A, 0, 8'h00, 0, 8'h00, 16'h005A, 16'h0000, 1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1, 16'h00E7, 1, 8'h96, 0, 8'h00, 16'h00E7, 16'h0096, 1};

    clk_wait(3);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    clk_wait(4);

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Random single frames against a word-level model: the target returns what was
    // buffered (or zero), and counts one underrun per reload that found the buffer empty.
    for (int i = 0; i < 24; i++) begin
      rv.cpol    = 1'($urandom_range(0, 1));
      rv.cpha    = 1'($urandom_range(0, 1));
      rv.lsb     = 1'($urandom_range(0, 1));
      rv.nfr     = 1;
      rv.mo      = {8'h00, 8'($urandom)};
      rv.pre     = 1'($urandom_range(0, 1));
      rv.tx0     = 8'($urandom);
      rv.mid     = 0;
      rv.tx1     = 8'h00;
      rv.exp_rx  = rv.mo;
      rv.exp_mi  = rv.pre ? {8'h00, rv.tx0} : 16'h0000;
      rv.exp_und = (rv.pre ? 0 : 1) + (rv.cpha ? 0 : 1);
      run_vec("rand", rv);
      last_rx = rv.mo[7:0];
    end

    // Deselect after three SCK cycles.
    r0 = rx_log.size(); f0 = ferr_total;
    xfer(1'b0, 1'b0, 1'b0, 3, 16'h00B7, mi, 1'b1);
    check("abort_frame_err", ferr_total - f0, 1);
    check("abort_no_rx", rx_log.size() - r0, 0);
    check("abort_rx_held", {24'd0, rx_data}, {24'd0, last_rx});
    check("abort_oe", {31'd0, miso_oe}, 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    push_tx(8'h77);
    xfer(1'b0, 1'b0, 1'b0, 4, 16'h00F0, mi, 1'b0);
    rst_n = 1'b0;
    clk_wait(2);
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_underrun", {31'd0, tx_underrun}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    cs_n = 1'b1;
    sck  = 1'b0;
    clk_wait(4);
    rst_n = 1'b1;
    clk_wait(8);
    r0 = rx_log.size(); f0 = ferr_total;
    xfer(1'b0, 1'b0, 1'b0, 8, 16'h00C3, mi, 1'b1);
    check("post_rst_rx_count", rx_log.size() - r0, 1);
    check("post_rst_rx_data", {24'd0, rx_data}, 32'h0000_00C3);
    check("post_rst_frame_errs", ferr_total - f0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
